// File: rtl/posit_pkg.sv
// Shared types and constants for the posit multiplier driver slice.
package posit_pkg;

  localparam int PW    = 32;
  localparam int ES    = 4;
  localparam int BYTES = PW / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    SETTLE,
    RD_HI,
    RD_LO,
    CAP,
    RESP
  } state_t;

  // Byte slot codes on the multiplier load port; slot 0 is the MSB.
  localparam logic [1:0] MODE_B3 = 2'd0;
  localparam logic [1:0] MODE_B2 = 2'd1;
  localparam logic [1:0] MODE_B1 = 2'd2;
  localparam logic [1:0] MODE_B0 = 2'd3;

  localparam logic [PW-1:0] NAR = 32'h8000_0000;

endpackage

// File: rtl/posit_byte_sel.sv
// Combinational 32->8 byte mux indexed by load slot (slot 0 = MSB).
module posit_byte_sel
  import posit_pkg::*;
(
  input  logic [PW-1:0] word,
  input  logic [1:0]    slot,
  output logic [7:0]    byte_out
);

  always_comb begin
    byte_out = word[7:0];
    case (slot)
      MODE_B3: byte_out = word[31:24];
      MODE_B2: byte_out = word[23:16];
      MODE_B1: byte_out = word[15:8];
      MODE_B0: byte_out = word[7:0];
      default: byte_out = word[7:0];
    endcase
  end

endmodule

// File: rtl/posit_mul_driver.sv
// Byte-serial load / 16-bit readback initiator for the posit multiplier,
// with valid/ready handshakes on the operand and result sides.
module posit_mul_driver
  import posit_pkg::*;
#(
  parameter int   SETTLE_CYCLES = 1,
  parameter logic B_CACHE       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [7:0]  pm_data_in,
  output logic        pm_a_b,
  output logic        pm_load,
  output logic        pm_in_out,
  output logic [1:0]  pm_mode_in,
  output logic        pm_mode_out,
  input  logic [15:0] pm_data_out
);

  localparam int             SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]     LAST_BYTE   = 2'(BYTES - 1);

  state_t          state, state_d;
  logic [1:0]      cnt, cnt_d;
  logic [SW-1:0]   set_cnt, set_d;
  logic [PW-1:0]   a_sh, b_sh, a_sh_d, b_sh_d;
  logic [PW-1:0]   b_last;
  logic            b_cache_vld;
  logic            accept, b_hit, load_d;
  logic [PW-1:0]   src_word;
  logic [7:0]      sel_byte;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign b_hit  = B_CACHE && b_cache_vld && (b_sh == b_last);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    set_d   = set_cnt;
    a_sh_d  = a_sh;
    b_sh_d  = b_sh;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = LOAD_A;
          cnt_d   = '0;
          a_sh_d  = op_a;
          b_sh_d  = op_b;
        end
      end
      LOAD_A: begin
        if (cnt == LAST_BYTE) begin
          cnt_d = '0;
          if (b_hit) begin
            state_d = SETTLE;
            set_d   = '0;
          end else begin
            state_d = LOAD_B;
          end
        end else begin
          cnt_d = cnt + 2'd1;
        end
      end
      LOAD_B: begin
        if (cnt == LAST_BYTE) begin
          state_d = SETTLE;
          cnt_d   = '0;
          set_d   = '0;
        end else begin
          cnt_d = cnt + 2'd1;
        end
      end
      SETTLE: begin
        if (set_cnt == SETTLE_LAST) state_d = RD_HI;
        else                        set_d   = set_cnt + SW'(1);
      end
      RD_HI:   state_d = RD_LO;
      RD_LO:   state_d = CAP;
      CAP:     state_d = RESP;
      RESP:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and latched with it, so every
  // port is a flop that lines up cycle-for-cycle with the state register.
  assign load_d   = (state_d == LOAD_A) || (state_d == LOAD_B);
  assign src_word = (state_d == LOAD_A) ? a_sh_d : b_sh_d;

  posit_byte_sel u_byte_sel (
    .word     (src_word),
    .slot     (cnt_d),
    .byte_out (sel_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      set_cnt     <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      b_last      <= '0;
      b_cache_vld <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      pm_data_in  <= '0;
      pm_a_b      <= 1'b0;
      pm_load     <= 1'b0;
      pm_in_out   <= 1'b0;
      pm_mode_in  <= '0;
      pm_mode_out <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      set_cnt     <= set_d;
      a_sh        <= a_sh_d;
      b_sh        <= b_sh_d;
      in_ready    <= (state_d == IDLE);
      out_valid   <= (state_d == RESP);
      pm_load     <= load_d;
      pm_a_b      <= (state_d == LOAD_A);
      pm_mode_in  <= load_d ? cnt_d : '0;
      pm_data_in  <= load_d ? sel_byte : '0;
      pm_in_out   <= (state_d == RD_HI) || (state_d == RD_LO) || (state_d == CAP);
      pm_mode_out <= (state_d == RD_HI);
      if (state == LOAD_B && cnt == LAST_BYTE) begin
        b_last      <= b_sh;
        b_cache_vld <= 1'b1;
      end
      // Readback data lags the half select by one cycle on the multiplier side.
      if (state == RD_LO) result[31:16] <= pm_data_out;
      if (state == CAP)   result[15:0]  <= pm_data_out;
    end
  end

endmodule

// File: tb/tb_posit_mul_driver.sv
// Self-checking bench for posit_mul_driver: default instance plus a SETTLE_CYCLES=3 instance,
// each wired to a behavioural multiplier with registered readback.
module tb_posit_mul_driver;

  typedef struct {
    int          inst;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    bit          hit;
    int          lat;
  } vec_t;

  typedef struct packed {
    logic       a_b;
    logic [1:0] mode;
    logic [7:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic [1:0]  reset, in_valid, out_ready;
  logic [1:0]  in_ready, out_valid, pm_a_b, pm_load, pm_in_out, pm_mode_out;
  logic [31:0] op_a[2], op_b[2], result[2];
  logic [7:0]  pm_data_in[2];
  logic [1:0]  pm_mode_in[2];
  logic [15:0] pm_data_out[2];
  logic [31:0] ma[2], mb[2];

  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;
  wr_t  bq[$];
  logic [31:0] rq[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  posit_mul_driver u_dut0 (
    .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op_a(op_a[0]), .op_b(op_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .pm_data_in(pm_data_in[0]), .pm_a_b(pm_a_b[0]), .pm_load(pm_load[0]),
    .pm_in_out(pm_in_out[0]), .pm_mode_in(pm_mode_in[0]), .pm_mode_out(pm_mode_out[0]),
    .pm_data_out(pm_data_out[0])
  );

  posit_mul_driver #(.SETTLE_CYCLES(3), .B_CACHE(1'b1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op_a(op_a[1]), .op_b(op_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .pm_data_in(pm_data_in[1]), .pm_a_b(pm_a_b[1]), .pm_load(pm_load[1]),
    .pm_in_out(pm_in_out[1]), .pm_mode_in(pm_mode_in[1]), .pm_mode_out(pm_mode_out[1]),
    .pm_data_out(pm_data_out[1])
  );

  // Stand-in product: zero if either operand is zero, else a mix that keeps halves distinct.
  function automatic logic [31:0] mock(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0 || b == 32'h0) return 32'h0;
    return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    logic [31:0] s;
    s = w >> (8 * (3 - i));
    return s[7:0];
  endfunction

  // Behavioural multiplier register file and registered readback port.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pm_load[k]) begin
        case (pm_mode_in[k])
          2'd0: if (pm_a_b[k]) ma[k][31:24] <= pm_data_in[k]; else mb[k][31:24] <= pm_data_in[k];
          2'd1: if (pm_a_b[k]) ma[k][23:16] <= pm_data_in[k]; else mb[k][23:16] <= pm_data_in[k];
          2'd2: if (pm_a_b[k]) ma[k][15:8]  <= pm_data_in[k]; else mb[k][15:8]  <= pm_data_in[k];
          default: if (pm_a_b[k]) ma[k][7:0] <= pm_data_in[k]; else mb[k][7:0] <= pm_data_in[k];
        endcase
      end
      if (pm_in_out[k]) begin
        if (pm_mode_out[k]) pm_data_out[k] <= mock(ma[k], mb[k]) >> 16;
        else                pm_data_out[k] <= mock(ma[k], mb[k]) & 32'h0000_FFFF;
      end
    end
  end

  // Byte-write scoreboard and load/readback exclusion on the active instance.
  always @(negedge clk) begin
    if (pm_in_out[cur]) begin
      checks++;
      if (pm_load[cur]) begin
        errors++;
        $display("FAIL load_overlap inst=%0d pm_load=1 while pm_in_out=1 (required pm_load=0)", cur);
      end
    end
    if (pm_load[cur]) begin
      wr_t got, e;
      got = {pm_a_b[cur], pm_mode_in[cur], pm_data_in[cur]};
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL byte_write inst=%0d unexpected write a_b=%0b mode=%0d data=%02h", cur, got.a_b, got.mode, got.data);
      end else begin
        e = bq.pop_front();
        if (got != e) begin
          errors++;
          $display("FAIL byte_write inst=%0d got a_b=%0b mode=%0d data=%02h required a_b=%0b mode=%0d data=%02h",
                   cur, got.a_b, got.mode, got.data, e.a_b, e.mode, e.data);
        end
      end
    end
  end

  task automatic check_reset(input int k);
    logic [47:0] outs;
    outs = {in_ready[k], out_valid[k], result[k], pm_data_in[k], pm_a_b[k], pm_load[k],
            pm_in_out[k], pm_mode_in[k], pm_mode_out[k]};
    checks++;
    if (outs != '0) begin
      errors++;
      $display("FAIL reset_outputs inst=%0d got %012h required 0", k, outs);
    end
  endtask

  task automatic push_bytes(input logic [31:0] a, input logic [31:0] b, input bit hit);
    for (int i = 0; i < 4; i++) bq.push_back({1'b1, 2'(i), byte_of(a, i)});
    if (!hit) for (int i = 0; i < 4; i++) bq.push_back({1'b0, 2'(i), byte_of(b, i)});
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!in_ready[cur] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready[cur];
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout inst=%0d in_ready=0 after %0d cycles (required 1)", cur, n);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int          n;
    bit          ok;
    logic [31:0] exp, held;
    cur = v.inst;
    wait_ready(ok);
    if (!ok) return;
    push_bytes(v.a, v.b, v.hit);
    rq.push_back(mock(v.a, v.b));
    op_a[cur] = v.a; op_b[cur] = v.b; in_valid[cur] = 1'b1;
    @(posedge clk); #1;
    in_valid[cur] = 1'b0;
    n = 0;
    while (!out_valid[cur] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != v.lat) begin
      errors++;
      $display("FAIL latency inst=%0d a=%08h got %0d cycles required %0d", cur, v.a, n, v.lat);
    end
    if (!out_valid[cur]) begin
      rq.delete(); bq.delete();
      return;
    end
    exp = rq.pop_front();
    checks++;
    if (result[cur] !== exp) begin
      errors++;
      $display("FAIL result inst=%0d a=%08h b=%08h got %08h required %08h", cur, v.a, v.b, result[cur], exp);
    end
    held = result[cur];
    if (v.hold > 0) begin
      in_valid[cur] = 1'b1; op_a[cur] = ~v.a; op_b[cur] = ~v.b;
      for (int h = 0; h < v.hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid[cur] !== 1'b1 || result[cur] !== held || in_ready[cur] !== 1'b0) begin
          errors++;
          $display("FAIL hold inst=%0d cyc=%0d got valid=%0b ready=%0b result=%08h required valid=1 ready=0 result=%08h",
                   cur, h, out_valid[cur], in_ready[cur], result[cur], held);
        end
      end
      in_valid[cur] = 1'b0;
    end
    out_ready[cur] = 1'b1;
    @(posedge clk); #1;
    out_ready[cur] = 1'b0;
    checks++;
    if (out_valid[cur] !== 1'b0 || in_ready[cur] !== 1'b1) begin
      errors++;
      $display("FAIL release inst=%0d got valid=%0b ready=%0b required valid=0 ready=1", cur, out_valid[cur], in_ready[cur]);
    end
    checks++;
    if (bq.size() != 0) begin
      errors++;
      $display("FAIL byte_count inst=%0d got %0d writes missing required 0", cur, bq.size());
    end
    bq.delete();
  endtask

  initial begin
    bit ok;
    int n;
    vecs[0] = '{0, 32'h4000_0000, 32'h4000_0000, 0, 1'b0, 12};
    vecs[1] = '{0, 32'h5000_0000, 32'h4000_0000, 0, 1'b1, 8};
    vecs[2] = '{0, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0, 12};
    vecs[3] = '{0, 32'hDEAD_BEEF, 32'h9ABC_DEF0, 0, 1'b1, 8};
    vecs[4] = '{0, 32'h8000_0000, 32'h1122_3344, 0, 1'b0, 12};
    vecs[5] = '{0, 32'h0BAD_0BAD, 32'h1122_3344, 0, 1'b0, 12};
    vecs[6] = '{0, 32'h0BAD_0BAD, 32'h1122_3344, 2, 1'b1, 8};
    vecs[7] = '{1, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 14};
    vecs[8] = '{1, 32'h7FFF_FFFF, 32'h0000_0000, 0, 1'b1, 10};

    for (int k = 0; k < 2; k++) begin
      op_a[k] = '0; op_b[k] = '0; pm_data_out[k] = '0; ma[k] = '0; mb[k] = '0;
    end
    in_valid = '0; out_ready = '0; reset = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    reset = 2'b00;

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Reset while LOAD_B is writing byte 2; the partial pair is abandoned.
    cur = 0;
    wait_ready(ok);
    if (ok) begin
      push_bytes(32'hCAFE_F00D, 32'h5566_7788, 1'b0);
      op_a[0] = 32'hCAFE_F00D; op_b[0] = 32'h5566_7788; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      n = 0;
      while (!(pm_load[0] && !pm_a_b[0] && pm_mode_in[0] == 2'd2) && n < 20) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (n >= 20) begin
        errors++;
        $display("FAIL reach_load_b2 no b-byte 2 write within %0d cycles (required one)", n);
      end
      reset[0] = 1'b1;
      @(posedge clk); #1;
      check_reset(0);
      reset[0] = 1'b0;
      bq.delete();
    end

    for (int i = 5; i < 9; i++) run_txn(vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
